// File: rtl/game_pkg.sv
// Shared types and helpers for the tic-tac-toe game sequencer.
// Board is a flat vector of nine 2-bit cell codes, cell i at bits [2i+1:2i].
package game_pkg;

    typedef enum logic [2:0] {StPlay, StWrite, StCheck, StWon, StDraw} state_t;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] X = 2'd1;
    localparam logic [1:0] O = 2'd2;

    localparam int NUM_CELLS = 9;
    localparam int CURSOR_W = 4;
    localparam int BOARD_W = 2 * NUM_CELLS;

    function automatic logic [1:0] cell_code(logic [BOARD_W-1:0] b, logic [CURSOR_W-1:0] idx);
        logic [1:0] c;
        c = EMPTY;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (idx == CURSOR_W'(i)) c = b[2*i +: 2];
        end
        return c;
    endfunction

    function automatic logic board_full(logic [BOARD_W-1:0] b);
        logic f;
        f = 1'b1;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (b[2*i +: 2] == EMPTY) f = 1'b0;
        end
        return f;
    endfunction

endpackage

// File: rtl/turn_timer.sv
// Per-turn countdown: tick divider plus seconds counter with a timeout on the
// first wrap after reaching zero.
module turn_timer #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned TURN_SECS = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       reload,
    output logic [3:0] time_left,
    output logic       timeout
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] tick_cnt;
    logic          wrap;

    assign wrap = run && (tick_cnt == CW'(TICK_DIV - 1));
    assign timeout = wrap && (time_left == 4'd0);

    always_ff @(posedge clk) begin
        if (rst || reload) begin
            tick_cnt  <= '0;
            time_left <= 4'(TURN_SECS);
        end else if (run) begin
            tick_cnt <= wrap ? '0 : tick_cnt + 1'b1;
            if (wrap && time_left != 4'd0) time_left <= time_left - 4'd1;
        end
    end

endmodule

// File: rtl/turn_scheduler.sv
// Game sequencer: owns cursor, turn and countdown, arbitrates board writes and
// decides win / draw / next turn from the registered win checker.
module turn_scheduler #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned TURN_SECS = 9,
    parameter int unsigned CHECK_CYCLES = 2
) (
    input  logic        clk,
    input  logic        boton_rst,
    input  logic        move_pulse,
    input  logic        select_pulse,
    input  logic [17:0] rd_board,
    input  logic        win,
    output logic        wr_en,
    output logic [3:0]  wr_addr,
    output logic [1:0]  wr_data,
    output logic [3:0]  cursor,
    output logic [1:0]  turn,
    output logic [3:0]  time_left,
    output logic        reject,
    output logic [1:0]  winner,
    output logic        draw,
    output logic        busy
);
    import game_pkg::*;

    state_t     state;
    logic [7:0] chk_cnt;
    logic       chk_done;
    logic       full;
    logic       run;
    logic       reload;
    logic       timeout;
    logic [3:0] low_empty;

    assign run      = (state == StPlay);
    assign chk_done = (chk_cnt == 8'(CHECK_CYCLES - 1));
    assign full     = board_full(rd_board);
    assign reload   = (state == StCheck) && chk_done && !win && !full;
    assign busy     = (state == StWrite) || (state == StCheck);

    // Lowest-indexed empty cell, used as the auto-move target on timeout.
    always_comb begin
        low_empty = 4'd0;
        for (int i = NUM_CELLS - 1; i >= 0; i--) begin
            if (rd_board[2*i +: 2] == EMPTY) low_empty = 4'(i);
        end
    end

    turn_timer #(
        .TICK_DIV (TICK_DIV),
        .TURN_SECS(TURN_SECS)
    ) u_timer (
        .clk      (clk),
        .rst      (boton_rst),
        .run      (run),
        .reload   (reload),
        .time_left(time_left),
        .timeout  (timeout)
    );

    always_ff @(posedge clk) begin
        if (boton_rst) begin
            state   <= StPlay;
            chk_cnt <= 8'd0;
            cursor  <= 4'd0;
            turn    <= X;
            wr_en   <= 1'b0;
            wr_addr <= 4'd0;
            wr_data <= EMPTY;
            reject  <= 1'b0;
            winner  <= EMPTY;
            draw    <= 1'b0;
        end else begin
            wr_en  <= 1'b0;
            reject <= 1'b0;
            unique case (state)
                StPlay: begin
                    // Select beats both a simultaneous move and a timeout.
                    if (select_pulse) begin
                        if (cell_code(rd_board, cursor) == EMPTY) begin
                            wr_addr <= cursor;
                            wr_data <= turn;
                            wr_en   <= 1'b1;
                            state   <= StWrite;
                        end else begin
                            reject <= 1'b1;
                        end
                    end else if (timeout) begin
                        wr_addr <= low_empty;
                        wr_data <= turn;
                        wr_en   <= 1'b1;
                        state   <= StWrite;
                    end else if (move_pulse) begin
                        cursor <= (cursor == 4'(NUM_CELLS - 1)) ? 4'd0 : cursor + 4'd1;
                    end
                end
                StWrite: begin
                    chk_cnt <= 8'd0;
                    state   <= StCheck;
                end
                StCheck: begin
                    if (!chk_done) begin
                        chk_cnt <= chk_cnt + 8'd1;
                    end else if (win) begin
                        winner <= turn;
                        state  <= StWon;
                    end else if (full) begin
                        draw  <= 1'b1;
                        state <= StDraw;
                    end else begin
                        turn  <= (turn == X) ? O : X;
                        state <= StPlay;
                    end
                end
                StWon, StDraw: begin
                end
                default: state <= StPlay;
            endcase
        end
    end

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed bench for turn_scheduler with a behavioural board register file and
// registered win checker; TICK_DIV=4, TURN_SECS=3, CHECK_CYCLES=2.
module tb_turn_scheduler;

    logic        clk = 1'b0;
    logic        boton_rst = 1'b1;
    logic        move_pulse = 1'b0;
    logic        select_pulse = 1'b0;
    logic [17:0] board;
    logic        win_q;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [1:0]  wr_data;
    logic [3:0]  cursor;
    logic [1:0]  turn;
    logic [3:0]  time_left;
    logic        reject;
    logic [1:0]  winner;
    logic        draw;
    logic        busy;

    logic        preload_en = 1'b0;
    logic [17:0] preload_val = '0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    turn_scheduler #(
        .TICK_DIV    (4),
        .TURN_SECS   (3),
        .CHECK_CYCLES(2)
    ) dut (
        .clk         (clk),
        .boton_rst   (boton_rst),
        .move_pulse  (move_pulse),
        .select_pulse(select_pulse),
        .rd_board    (board),
        .win         (win_q),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .cursor      (cursor),
        .turn        (turn),
        .time_left   (time_left),
        .reject      (reject),
        .winner      (winner),
        .draw        (draw),
        .busy        (busy)
    );

    function automatic logic [1:0] c(logic [17:0] b, int i);
        return b[2*i +: 2];
    endfunction

    function automatic logic line3(logic [17:0] b, int i, int j, int k);
        return (c(b, i) != 2'd0) && (c(b, i) == c(b, j)) && (c(b, j) == c(b, k));
    endfunction

    function automatic logic has_line(logic [17:0] b);
        return line3(b, 0, 1, 2) || line3(b, 3, 4, 5) || line3(b, 6, 7, 8) ||
               line3(b, 0, 3, 6) || line3(b, 1, 4, 7) || line3(b, 2, 5, 8) ||
               line3(b, 0, 4, 8) || line3(b, 2, 4, 6);
    endfunction

    // Board register file and registered winner checker.
    always @(posedge clk) begin
        if (boton_rst) board <= '0;
        else if (preload_en) board <= preload_val;
        else if (wr_en) board[int'(wr_addr)*2 +: 2] <= wr_data;
        win_q <= boton_rst ? 1'b0 : has_line(board);
    end

    typedef struct {
        logic       mv;
        logic       sel;
        logic [3:0] cur;
        logic       we;
        logic [3:0] addr;
        logic [1:0] data;
        logic       rej;
        logic [1:0] trn;
        logic [3:0] tl;
        logic       bsy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(int mv, int sel, int cur, int we, int addr, int data, int rej, int trn,
                       int tl, int bsy);
        vec_t v;
        v.mv = mv[0]; v.sel = sel[0]; v.cur = cur[3:0]; v.we = we[0]; v.addr = addr[3:0];
        v.data = data[1:0]; v.rej = rej[0]; v.trn = trn[1:0]; v.tl = tl[3:0]; v.bsy = bsy[0];
        vecs.push_back(v);
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        boton_rst = 1'b1;
        move_pulse = 1'b0;
        select_pulse = 1'b0;
        preload_en = 1'b0;
        tick();
        tick();
        boton_rst = 1'b0;
    endtask

    task automatic pulse(logic mv, logic sel);
        move_pulse = mv;
        select_pulse = sel;
        tick();
        move_pulse = 1'b0;
        select_pulse = 1'b0;
    endtask

    task automatic preload(logic [17:0] val);
        preload_val = val;
        preload_en = 1'b1;
        tick();
        preload_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [17:0] pv;

        // Reset values.
        boton_rst = 1'b1;
        tick();
        tick();
        check("rst cursor", 32'(cursor), 0);
        check("rst turn", 32'(turn), 1);
        check("rst time_left", 32'(time_left), 3);
        check("rst wr_en", 32'(wr_en), 0);
        check("rst reject", 32'(reject), 0);
        check("rst winner", 32'(winner), 0);
        check("rst draw", 32'(draw), 0);
        check("rst busy", 32'(busy), 0);
        check("rst wr_addr", 32'(wr_addr), 0);
        check("rst wr_data", 32'(wr_data), 0);
        boton_rst = 1'b0;

        //   mv sel cur we addr data rej trn tl bsy
        add(1, 0, 1, 0, 0, 0, 0, 1, 3, 0);
        add(1, 0, 2, 0, 0, 0, 0, 1, 3, 0);
        add(1, 0, 3, 0, 0, 0, 0, 1, 3, 0);
        add(1, 0, 4, 0, 0, 0, 0, 1, 2, 0);
        add(1, 0, 5, 0, 0, 0, 0, 1, 2, 0);
        add(1, 0, 6, 0, 0, 0, 0, 1, 2, 0);
        add(1, 0, 7, 0, 0, 0, 0, 1, 2, 0);
        add(1, 0, 8, 0, 0, 0, 0, 1, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        add(1, 0, 1, 0, 0, 0, 0, 1, 1, 0);
        add(1, 0, 2, 0, 0, 0, 0, 1, 1, 0);
        add(1, 0, 3, 0, 0, 0, 0, 1, 0, 0);
        add(1, 0, 4, 0, 0, 0, 0, 1, 0, 0);
        add(0, 1, 4, 1, 4, 1, 0, 1, 0, 1);   // commit on empty cell 4
        add(0, 0, 4, 0, 0, 0, 0, 1, 0, 1);
        add(0, 0, 4, 0, 0, 0, 0, 1, 0, 1);
        add(0, 0, 4, 0, 0, 0, 0, 2, 3, 0);   // O to move, timer reloaded
        add(0, 1, 4, 0, 0, 0, 1, 2, 3, 0);   // occupied -> reject
        add(0, 0, 4, 0, 0, 0, 0, 2, 3, 0);
        add(1, 0, 5, 0, 0, 0, 0, 2, 3, 0);
        add(1, 1, 5, 1, 5, 2, 0, 2, 2, 1);   // select wins over move
        add(0, 0, 5, 0, 0, 0, 0, 2, 2, 1);
        add(0, 0, 5, 0, 0, 0, 0, 2, 2, 1);
        add(0, 0, 5, 0, 0, 0, 0, 1, 3, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            pulse(vecs[i].mv, vecs[i].sel);
            check($sformatf("vec%0d cursor", i), 32'(cursor), 32'(vecs[i].cur));
            check($sformatf("vec%0d wr_en", i), 32'(wr_en), 32'(vecs[i].we));
            if (vecs[i].we) begin
                check($sformatf("vec%0d wr_addr", i), 32'(wr_addr), 32'(vecs[i].addr));
                check($sformatf("vec%0d wr_data", i), 32'(wr_data), 32'(vecs[i].data));
            end
            check($sformatf("vec%0d reject", i), 32'(reject), 32'(vecs[i].rej));
            check($sformatf("vec%0d turn", i), 32'(turn), 32'(vecs[i].trn));
            check($sformatf("vec%0d time_left", i), 32'(time_left), 32'(vecs[i].tl));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].bsy));
        end

        // Timeout auto-move: cells 0,1 taken, expect write to cell 2 at cycle 16.
        do_reset();
        pv = '0;
        pv[1:0] = 2'd1;
        pv[3:2] = 2'd2;
        preload(pv);
        repeat (14) tick();
        check("to pre wr_en", 32'(wr_en), 0);
        check("to pre time_left", 32'(time_left), 0);
        tick();
        check("to wr_en", 32'(wr_en), 1);
        check("to wr_addr", 32'(wr_addr), 2);
        check("to wr_data", 32'(wr_data), 1);
        check("to cursor", 32'(cursor), 0);

        // X completes the top row.
        do_reset();
        pv = '0;
        pv[1:0] = 2'd1;
        pv[3:2] = 2'd1;
        pv[7:6] = 2'd2;
        pv[9:8] = 2'd2;
        preload(pv);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        check("win wr_en", 32'(wr_en), 1);
        check("win wr_addr", 32'(wr_addr), 2);
        tick();
        tick();
        check("win pre winner", 32'(winner), 0);
        tick();
        check("win winner", 32'(winner), 1);
        check("win busy", 32'(busy), 0);
        check("win draw", 32'(draw), 0);
        for (int i = 0; i < 4; i++) begin
            pulse(1'b1, 1'b1);
            check($sformatf("won%0d wr_en", i), 32'(wr_en), 0);
            check($sformatf("won%0d reject", i), 32'(reject), 0);
            check($sformatf("won%0d cursor", i), 32'(cursor), 2);
        end
        repeat (8) tick();
        check("won time_left", 32'(time_left), 2);
        check("won turn", 32'(turn), 1);
        check("won winner hold", 32'(winner), 1);

        // Last empty cell 0 filled without a line -> draw.
        do_reset();
        pv = '0;
        pv[3:2] = 2'd2; pv[5:4] = 2'd1;
        pv[7:6] = 2'd1; pv[9:8] = 2'd2; pv[11:10] = 2'd2;
        pv[13:12] = 2'd2; pv[15:14] = 2'd1; pv[17:16] = 2'd1;
        preload(pv);
        pulse(1'b0, 1'b1);
        check("draw wr_en", 32'(wr_en), 1);
        check("draw wr_addr", 32'(wr_addr), 0);
        tick();
        tick();
        tick();
        check("draw flag", 32'(draw), 1);
        check("draw winner", 32'(winner), 0);
        check("draw turn", 32'(turn), 1);
        pulse(1'b0, 1'b1);
        check("draw sel wr_en", 32'(wr_en), 0);
        check("draw sel reject", 32'(reject), 0);

        // Reset while in CHECK abandons the pending turn change.
        do_reset();
        pulse(1'b0, 1'b1);
        tick();
        tick();
        tick();
        check("rc turn2", 32'(turn), 2);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        check("rc wr_en", 32'(wr_en), 1);
        tick();
        check("rc busy", 32'(busy), 1);
        boton_rst = 1'b1;
        tick();
        check("rc after wr_en", 32'(wr_en), 0);
        check("rc after turn", 32'(turn), 1);
        check("rc after cursor", 32'(cursor), 0);
        check("rc after busy", 32'(busy), 0);
        check("rc after time_left", 32'(time_left), 3);
        boton_rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/turn_scheduler.md
# turn_scheduler

Game sequencer for the tic-tac-toe VGA design. It sits between the debounced player buttons and the board register file, and arbitrates all board writes. It owns the cursor, the turn and the per-turn countdown. It issues single-cycle writes for player commits and timeout auto-moves, then waits for the registered win checker before deciding win, draw or next turn.

## Interface
Parameters:
- TICK_DIV, 50_000_000: clk cycles per countdown second.
- TURN_SECS, 9: seconds allowed per turn (1..15).
- CHECK_CYCLES, 2: cycles waited after a write before sampling `win` (≥1).

Ports:
- clk  in  1  system clock; the only clock.
- boton_rst  in  1  reset, synchronous, active-high.
- move_pulse  in  1  one-cycle debounced pulse; advance cursor.
- select_pulse  in  1  one-cycle debounced pulse; commit at cursor.
- rd_board  in  9×2  current cell codes from the register file.
- win  in  1  win flag from the winner checker; registered.
- wr_en  out  1  one-cycle board write strobe.
- wr_addr  out  4  write cell index, 0..8.
- wr_data  out  2  write code, equal to the current turn.
- cursor  out  4  selected cell, 0..8.
- turn  out  2  player to move: 1 = X, 2 = O.
- time_left  out  4  seconds remaining in this turn.
- reject  out  1  one-cycle pulse: select on an occupied cell.
- winner  out  2  0 = none, else the winning code.
- draw  out  1  board full with no win.
- busy  out  1  high in WRITE/CHECK; inputs are ignored.

## Operation
- FSM states: PLAY, WRITE, CHECK, WON, DRAW.
- PLAY, on select_pulse:
  - If `rd_board[cursor]==0`: latch `wr_addr=cursor` and go to WRITE.
  - Otherwise pulse `reject`, stay in PLAY, leave the timer running.
- PLAY, on move_pulse without select_pulse: cursor increments, wrapping 8→0.
- PLAY, select_pulse and move_pulse in the same cycle: select wins; the move is dropped and the cursor is unchanged.
- PLAY, timeout: when `time_left==0` and a second tick arrives, auto-commit.
  - `wr_addr` is the lowest-indexed empty cell; go to WRITE.
  - The cursor is not moved.
  - If a player select and the timeout occur in the same cycle, the player select wins.
- WRITE (exactly 1 cycle): `wr_en=1`, `wr_data=turn`; go to CHECK.
- CHECK (CHECK_CYCLES cycles), then sample `win` and `rd_board`:
  - If `win`: go to WON and set `winner=turn`.
  - Else if all 9 cells are nonzero: go to DRAW and set `draw=1`.
  - Else: toggle turn 1↔2, reload `time_left=TURN_SECS`, clear the tick counter, go to PLAY.
- WON and DRAW are terminal until reset:
  - All pulses are ignored; no `reject` is generated.
  - The timer is frozen; `wr_en` stays 0.
- Timer: the tick counter counts 0..TICK_DIV-1 only in PLAY.
  - On wrap, `time_left` decrements, saturating at 0.
  - The following wrap while at 0 is the timeout.
- Reset values:
  - state PLAY, cursor 0, turn 1, time_left TURN_SECS, tick counter 0.
  - wr_en/reject/draw 0, winner 0, wr_addr 0, wr_data 0.
- The register file is cleared by the same `boton_rst`; this block does not clear it.

## Timing
- Select to `wr_en`: the select in cycle N yields `wr_en` in N+1. The cell is visible in `rd_board` at N+2.
- The decision is taken at cycle N+1+CHECK_CYCLES. The new turn or terminal state is visible in the following cycle.
- Turn length: (TURN_SECS+1)·TICK_DIV cycles from PLAY entry to the auto-commit decision.
- Reset mid-WRITE/CHECK: the pending write is abandoned (`wr_en` low in the next cycle) and all reset values apply.
- `reject` and `wr_en` are never high in the same cycle.

## Structure
- Shared `game_pkg` holds:
  - The state enum.
  - Cell codes EMPTY=0, X=1, O=2.
  - NUM_CELLS=9 and the cursor width.
- Sub-module `turn_timer`:
  - Contains the tick divider and the `time_left` counter.
  - Inputs: `run`, `reload`.
  - Outputs: `time_left`, `timeout`.
- The lowest-empty-cell priority encoder stays inline.

## Test plan
All scenarios use TICK_DIV=4, TURN_SECS=3, CHECK_CYCLES=2.
- Reset → cursor 0, turn 1, time_left 3, all strobes 0. Nine move_pulses → cursor cycles 1..8 and then 0.
- Select on empty cell 4 → `wr_en` one cycle later with addr 4, data 1. Three cycles after the strobe, turn=2 and time_left=3.
- Select on an occupied cell → `reject` for one cycle; no `wr_en`; turn and timer unchanged. Simultaneous move+select on an empty cell → commit at the old cursor; the cursor does not move.
- No input with cells 0 and 1 occupied → after 16 cycles in PLAY, `wr_en` with addr 2 and data equal to turn.
- X fills cells 0, 1, 2 with `win` asserted after the third write → `winner=1`, state WON. Later pulses produce no `wr_en` and no `reject`.
- Full board with no win → `draw=1`. Reset asserted during CHECK → `wr_en` 0, turn 1, cursor 0 on the next cycle.
